// File: rtl/m_store_align.sv
// E->M pipeline register for stores: places store data into byte lanes, drives byte
// enables to data memory, flags store address errors and counts committed stores.
module m_store_align #(
  parameter logic [31:0] DM_BASE  = 32'h0000_0000,
  parameter logic [31:0] DM_LIMIT = 32'h0000_2FFF,
  // Value loaded into the store counter on reset; leave at 0 outside of test benches.
  parameter logic [31:0] CNT_RST  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        flush,
  input  logic [1:0]  E_StoreOp,
  input  logic [31:0] E_addr,
  input  logic [31:0] E_wdata,
  input  logic [31:0] E_pc,
  output logic [31:0] M_addr,
  output logic [31:0] M_wdata,
  output logic [3:0]  M_byteen,
  output logic [31:0] M_pc,
  output logic        M_AdES,
  output logic [31:0] M_store_cnt
);

  localparam logic [1:0] OP_SB = 2'b01;
  localparam logic [1:0] OP_SH = 2'b10;
  localparam logic [1:0] OP_SW = 2'b11;

  logic [1:0]  w_a;
  logic [3:0]  w_byteen_raw;
  logic [3:0]  w_byteen;
  logic [31:0] w_wdata;
  logic        w_misalign;
  logic [32:0] w_base_diff;
  logic        w_below;
  logic        w_above;
  logic        w_ades;

  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_byteen;
  logic [31:0] r_pc;
  logic        r_ades;
  logic [31:0] r_store_cnt;

  assign w_a = E_addr[1:0];

  always_comb begin
    w_byteen_raw = 4'b0000;
    w_wdata      = 32'h0000_0000;
    w_misalign   = 1'b0;
    case (E_StoreOp)
      OP_SB: begin
        w_byteen_raw = 4'b0001 << w_a;
        w_wdata      = {4{E_wdata[7:0]}};
      end
      OP_SH: begin
        w_byteen_raw = w_a[1] ? 4'b1100 : 4'b0011;
        w_wdata      = {2{E_wdata[15:0]}};
        w_misalign   = w_a[0];
      end
      OP_SW: begin
        w_byteen_raw = 4'b1111;
        w_wdata      = E_wdata;
        w_misalign   = |w_a;
      end
      default: begin
        w_byteen_raw = 4'b0000;
        w_wdata      = 32'h0000_0000;
        w_misalign   = 1'b0;
      end
    endcase
  end

  // Borrow out of the subtraction gives addr < base without a constant-compare against 0.
  assign w_base_diff = {1'b0, E_addr} - {1'b0, DM_BASE};
  assign w_below     = w_base_diff[32];
  assign w_above     = E_addr > DM_LIMIT;
  assign w_ades      = (|E_StoreOp) & (w_misalign | w_below | w_above);
  assign w_byteen    = w_ades ? 4'b0000 : w_byteen_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr      <= 32'h0000_0000;
      r_wdata     <= 32'h0000_0000;
      r_byteen    <= 4'b0000;
      r_pc        <= 32'h0000_0000;
      r_ades      <= 1'b0;
      r_store_cnt <= CNT_RST;
    end else if (flush) begin
      r_addr   <= 32'h0000_0000;
      r_wdata  <= 32'h0000_0000;
      r_byteen <= 4'b0000;
      r_pc     <= 32'h0000_0000;
      r_ades   <= 1'b0;
    end else if (en) begin
      r_addr      <= {E_addr[31:2], 2'b00};
      r_wdata     <= w_wdata;
      r_byteen    <= w_byteen;
      r_pc        <= E_pc;
      r_ades      <= w_ades;
      r_store_cnt <= r_store_cnt + {31'b0, |w_byteen};
    end
  end

  assign M_addr      = r_addr;
  assign M_wdata     = r_wdata;
  assign M_byteen    = r_byteen;
  assign M_pc        = r_pc;
  assign M_AdES      = r_ades;
  assign M_store_cnt = r_store_cnt;

endmodule

// File: tb/tb_m_store_align.sv
// Directed bench for m_store_align: lane placement, AdES, stall/flush, counter and wrap.
module tb_m_store_align;

  logic        clk = 1'b0;
  logic        reset, reset_w, en, flush;
  logic [1:0]  E_StoreOp;
  logic [31:0] E_addr, E_wdata, E_pc;
  logic [31:0] M_addr, M_wdata, M_pc, M_store_cnt;
  logic [3:0]  M_byteen;
  logic        M_AdES;
  logic [31:0] W_addr, W_wdata, W_pc, W_store_cnt;
  logic [3:0]  W_byteen;
  logic        W_AdES;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_cnt;

  always #5 clk = ~clk;

  m_store_align dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .E_StoreOp(E_StoreOp), .E_addr(E_addr), .E_wdata(E_wdata), .E_pc(E_pc),
    .M_addr(M_addr), .M_wdata(M_wdata), .M_byteen(M_byteen), .M_pc(M_pc),
    .M_AdES(M_AdES), .M_store_cnt(M_store_cnt)
  );

  // Second instance with the counter preloaded just below wrap.
  m_store_align #(.CNT_RST(32'hFFFF_FFFF)) u_wrap (
    .clk(clk), .reset(reset_w), .en(en), .flush(flush),
    .E_StoreOp(E_StoreOp), .E_addr(E_addr), .E_wdata(E_wdata), .E_pc(E_pc),
    .M_addr(W_addr), .M_wdata(W_wdata), .M_byteen(W_byteen), .M_pc(W_pc),
    .M_AdES(W_AdES), .M_store_cnt(W_store_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] pc);
    E_StoreOp = op;
    E_addr    = a;
    E_wdata   = d;
    E_pc      = pc;
  endtask

  task automatic test_reset();
    reset = 1'b1; reset_w = 1'b1; en = 1'b1; flush = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 32'h0);
    tick();
    reset_w = 1'b0;
    n_checks++;
    if ({M_addr, M_wdata, M_byteen, M_pc, M_AdES, M_store_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_init: got addr=%h wdata=%h be=%b pc=%h ades=%b cnt=%h, expected all zero",
               M_addr, M_wdata, M_byteen, M_pc, M_AdES, M_store_cnt);
    end
    reset = 1'b0;
    drive(2'b11, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0040);
    tick();
    n_checks++;
    if (M_byteen !== 4'b1111 || M_store_cnt !== 32'd1 || M_wdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL reset_pre_sw: got be=%b cnt=%0d wdata=%h, expected 1111 1 deadbeef",
               M_byteen, M_store_cnt, M_wdata);
    end
    reset = 1'b1; flush = 1'b1;
    tick();
    n_checks++;
    if ({M_addr, M_wdata, M_byteen, M_pc, M_AdES, M_store_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_midstream: got addr=%h wdata=%h be=%b pc=%h ades=%b cnt=%h, expected all zero",
               M_addr, M_wdata, M_byteen, M_pc, M_AdES, M_store_cnt);
    end
    reset = 1'b0; flush = 1'b0;
    exp_cnt = 32'd0;
  endtask

  task automatic test_sb();
    drive(2'b01, 32'h0000_1003, 32'h1234_56AB, 32'h0000_0100);
    tick();
    exp_cnt++;
    n_checks++;
    if (M_byteen !== 4'b1000 || M_wdata !== 32'hABAB_ABAB || M_addr !== 32'h0000_1000 ||
        M_pc !== 32'h0000_0100 || M_AdES !== 1'b0 || M_store_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL sb_lane3: got be=%b wdata=%h addr=%h pc=%h ades=%b cnt=%0d, expected 1000 ababab ab 1000 100 0 %0d",
               M_byteen, M_wdata, M_addr, M_pc, M_AdES, M_store_cnt, exp_cnt);
    end
    drive(2'b01, 32'h0000_1000, 32'hFFFF_FF5C, 32'h0000_0104);
    tick();
    exp_cnt++;
    n_checks++;
    if (M_byteen !== 4'b0001 || M_wdata !== 32'h5C5C_5C5C || M_store_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL sb_lane0: got be=%b wdata=%h cnt=%0d, expected 0001 5c5c5c5c %0d",
               M_byteen, M_wdata, M_store_cnt, exp_cnt);
    end
  endtask

  task automatic test_sh();
    drive(2'b10, 32'h0000_0002, 32'h0000_BEEF, 32'h0000_0200);
    tick();
    exp_cnt++;
    n_checks++;
    if (M_byteen !== 4'b1100 || M_wdata !== 32'hBEEF_BEEF || M_AdES !== 1'b0 ||
        M_store_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL sh_upper: got be=%b wdata=%h ades=%b cnt=%0d, expected 1100 beefbeef 0 %0d",
               M_byteen, M_wdata, M_AdES, M_store_cnt, exp_cnt);
    end
    drive(2'b10, 32'h0000_0001, 32'h0000_BEEF, 32'h0000_0204);
    tick();
    n_checks++;
    if (M_AdES !== 1'b1 || M_byteen !== 4'b0000 || M_store_cnt !== exp_cnt ||
        M_pc !== 32'h0000_0204 || M_addr !== 32'h0000_0000) begin
      n_fail++;
      $display("FAIL sh_misalign: got ades=%b be=%b cnt=%0d pc=%h addr=%h, expected 1 0000 %0d 204 0",
               M_AdES, M_byteen, M_store_cnt, M_pc, M_addr, exp_cnt);
    end
    drive(2'b10, 32'h0000_0000, 32'h1111_CAFE, 32'h0000_0208);
    tick();
    exp_cnt++;
    n_checks++;
    if (M_byteen !== 4'b0011 || M_wdata !== 32'hCAFE_CAFE || M_AdES !== 1'b0 ||
        M_store_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL sh_lower: got be=%b wdata=%h ades=%b cnt=%0d, expected 0011 cafecafe 0 %0d",
               M_byteen, M_wdata, M_AdES, M_store_cnt, exp_cnt);
    end
  endtask

  task automatic test_sw();
    drive(2'b11, 32'h0000_3000, 32'h0102_0304, 32'h0000_0300);
    tick();
    n_checks++;
    if (M_AdES !== 1'b1 || M_byteen !== 4'b0000 || M_addr !== 32'h0000_3000 ||
        M_store_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL sw_above_limit: got ades=%b be=%b addr=%h cnt=%0d, expected 1 0000 3000 %0d",
               M_AdES, M_byteen, M_addr, M_store_cnt, exp_cnt);
    end
    drive(2'b11, 32'h0000_2FFC, 32'h0102_0304, 32'h0000_0304);
    tick();
    exp_cnt++;
    n_checks++;
    if (M_AdES !== 1'b0 || M_byteen !== 4'b1111 || M_wdata !== 32'h0102_0304 ||
        M_addr !== 32'h0000_2FFC || M_store_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL sw_top_word: got ades=%b be=%b wdata=%h addr=%h cnt=%0d, expected 0 1111 01020304 2ffc %0d",
               M_AdES, M_byteen, M_wdata, M_addr, M_store_cnt, exp_cnt);
    end
    drive(2'b11, 32'h0000_2FFE, 32'h0102_0304, 32'h0000_0308);
    tick();
    n_checks++;
    if (M_AdES !== 1'b1 || M_byteen !== 4'b0000 || M_store_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL sw_misalign: got ades=%b be=%b cnt=%0d, expected 1 0000 %0d",
               M_AdES, M_byteen, M_store_cnt, exp_cnt);
    end
    drive(2'b01, 32'h0000_2FFF, 32'h0000_0077, 32'h0000_030C);
    tick();
    exp_cnt++;
    n_checks++;
    if (M_AdES !== 1'b0 || M_byteen !== 4'b1000 || M_wdata !== 32'h7777_7777 ||
        M_store_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL sb_limit_byte: got ades=%b be=%b wdata=%h cnt=%0d, expected 0 1000 77777777 %0d",
               M_AdES, M_byteen, M_wdata, M_store_cnt, exp_cnt);
    end
    drive(2'b01, 32'h0000_3000, 32'h0000_0077, 32'h0000_0310);
    tick();
    n_checks++;
    if (M_AdES !== 1'b1 || M_byteen !== 4'b0000 || M_store_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL sb_past_limit: got ades=%b be=%b cnt=%0d, expected 1 0000 %0d",
               M_AdES, M_byteen, M_store_cnt, exp_cnt);
    end
  endtask

  task automatic test_none();
    drive(2'b00, 32'h0000_1237, 32'hFFFF_FFFF, 32'h0000_0400);
    tick();
    n_checks++;
    if (M_byteen !== 4'b0000 || M_wdata !== 32'h0 || M_AdES !== 1'b0 ||
        M_addr !== 32'h0000_1234 || M_pc !== 32'h0000_0400 || M_store_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL none_op: got be=%b wdata=%h ades=%b addr=%h pc=%h cnt=%0d, expected 0000 0 0 1234 400 %0d",
               M_byteen, M_wdata, M_AdES, M_addr, M_pc, M_store_cnt, exp_cnt);
    end
  endtask

  task automatic test_stall();
    drive(2'b11, 32'h0000_0020, 32'h1122_3344, 32'h0000_0500);
    tick();
    exp_cnt++;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(2'b01, 32'h0000_1001 + i, 32'hA0A0_A0A0 + i, 32'h0000_0600 + 4 * i);
      tick();
      n_checks++;
      if (M_byteen !== 4'b1111 || M_wdata !== 32'h1122_3344 || M_addr !== 32'h0000_0020 ||
          M_pc !== 32'h0000_0500 || M_store_cnt !== exp_cnt) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got be=%b wdata=%h addr=%h pc=%h cnt=%0d, expected 1111 11223344 20 500 %0d",
                 i, M_byteen, M_wdata, M_addr, M_pc, M_store_cnt, exp_cnt);
      end
    end
    flush = 1'b1;
    tick();
    n_checks++;
    if (M_byteen !== 4'b0000 || M_pc !== 32'h0 || M_wdata !== 32'h0 || M_addr !== 32'h0 ||
        M_AdES !== 1'b0 || M_store_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL flush_in_stall: got be=%b pc=%h wdata=%h addr=%h ades=%b cnt=%0d, expected zeros cnt=%0d",
               M_byteen, M_pc, M_wdata, M_addr, M_AdES, M_store_cnt, exp_cnt);
    end
    flush = 1'b0; en = 1'b1;
  endtask

  task automatic test_back_to_back();
    drive(2'b01, 32'h0000_0005, 32'h0000_00A5, 32'h0000_0700);
    tick();
    exp_cnt++;
    n_checks++;
    if (M_byteen !== 4'b0010 || M_wdata !== 32'hA5A5_A5A5 || M_store_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL b2b_sb: got be=%b wdata=%h cnt=%0d, expected 0010 a5a5a5a5 %0d",
               M_byteen, M_wdata, M_store_cnt, exp_cnt);
    end
    drive(2'b10, 32'h0000_0006, 32'h0000_1234, 32'h0000_0704);
    tick();
    exp_cnt++;
    n_checks++;
    if (M_byteen !== 4'b1100 || M_wdata !== 32'h1234_1234 || M_pc !== 32'h0000_0704 ||
        M_store_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL b2b_sh: got be=%b wdata=%h pc=%h cnt=%0d, expected 1100 12341234 704 %0d",
               M_byteen, M_wdata, M_pc, M_store_cnt, exp_cnt);
    end
    drive(2'b11, 32'h0000_0008, 32'hCAFE_F00D, 32'h0000_0708);
    tick();
    exp_cnt++;
    n_checks++;
    if (M_byteen !== 4'b1111 || M_wdata !== 32'hCAFE_F00D || M_addr !== 32'h0000_0008 ||
        M_store_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL b2b_sw: got be=%b wdata=%h addr=%h cnt=%0d, expected 1111 cafef00d 8 %0d",
               M_byteen, M_wdata, M_addr, M_store_cnt, exp_cnt);
    end
    flush = 1'b1;
    drive(2'b11, 32'h0000_000C, 32'h5555_5555, 32'h0000_070C);
    tick();
    n_checks++;
    if (M_byteen !== 4'b0000 || M_pc !== 32'h0 || M_store_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL flush_enabled: got be=%b pc=%h cnt=%0d, expected 0000 0 %0d",
               M_byteen, M_pc, M_store_cnt, exp_cnt);
    end
    flush = 1'b0;
  endtask

  task automatic test_wrap();
    reset_w = 1'b1;
    drive(2'b00, 32'h0, 32'h0, 32'h0);
    tick();
    reset_w = 1'b0;
    n_checks++;
    if (W_store_cnt !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL wrap_preload: got cnt=%h, expected ffffffff", W_store_cnt);
    end
    drive(2'b01, 32'h0000_0010, 32'h0000_0042, 32'h0000_0800);
    tick();
    n_checks++;
    if (W_store_cnt !== 32'h0 || W_byteen !== 4'b0001) begin
      n_fail++;
      $display("FAIL wrap_to_zero: got cnt=%h be=%b, expected 00000000 0001", W_store_cnt, W_byteen);
    end
    drive(2'b00, 32'h0000_0010, 32'h0000_0042, 32'h0000_0804);
    tick();
    n_checks++;
    if (W_store_cnt !== 32'h0 || W_byteen !== 4'b0000) begin
      n_fail++;
      $display("FAIL wrap_none_hold: got cnt=%h be=%b, expected 00000000 0000", W_store_cnt, W_byteen);
    end
  endtask

  initial begin
    reset = 1'b1; reset_w = 1'b1; en = 1'b0; flush = 1'b0;
    exp_cnt = 32'd0;
    drive(2'b00, 32'h0, 32'h0, 32'h0);
    test_reset();
    test_sb();
    test_sh();
    test_sw();
    test_none();
    test_stall();
    test_back_to_back();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
